// File: rtl/dinv_seq.sv
// Pattern sequencer and checker for the dinv inverter: plays a loadable (level, hold) table onto
// `a` after a fixed low period and counts cycles where `y` is not the inverse of `a`.
module dinv_seq #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned CW          = 8,
  parameter int unsigned INIT_CYCLES = 100,
  parameter int unsigned ECW         = 8,
  localparam int unsigned AW         = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [CW:0]   wr_data,
  input  logic [AW:0]   len,
  input  logic          start,
  input  logic          abort,
  output logic          a,
  input  logic          y,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] step,
  output logic [ECW-1:0] err_cnt
);

  // Down-counter must hold both the init period and any hold value.
  localparam int unsigned IW  = $clog2(INIT_CYCLES + 1);
  localparam int unsigned CTW = (IW > CW) ? IW : CW;

  typedef enum logic [1:0] {StIdle, StInit, StPlay, StDone} state_e;

  state_e          state_q, state_d;
  logic [CTW-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]   step_q, step_d;
  logic [AW:0]     eff_len_q, eff_len_d;
  logic            a_q, a_d;
  logic [ECW-1:0]  err_q, err_d;
  logic [CW:0]     tab_q [DEPTH];
  logic [CW:0]     nxt_entry;

  function automatic logic [CTW-1:0] hold_len(logic [CW:0] e);
    return (e[CW-1:0] == '0) ? CTW'(1) : CTW'(e[CW-1:0]);
  endfunction

  // Table has no reset and is writable only while idle.
  always_ff @(posedge clk) begin
    if (wr_en && (state_q == StIdle)) begin
      tab_q[wr_addr] <= wr_data;
    end
  end

  assign nxt_entry = tab_q[step_q + AW'(1)];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    step_d    = step_q;
    eff_len_d = eff_len_q;
    a_d       = a_q;
    err_d     = err_q;

    if ((state_q == StInit || state_q == StPlay) && (y == a_q) && (err_q != {ECW{1'b1}})) begin
      err_d = err_q + ECW'(1);
    end

    unique case (state_q)
      StIdle: begin
        a_d = 1'b0;
        if (start && (len != '0)) begin
          state_d   = StInit;
          cnt_d     = CTW'(INIT_CYCLES);
          step_d    = '0;
          err_d     = '0;
          eff_len_d = (len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : len;
        end
      end
      StInit: begin
        if (abort) begin
          state_d = StIdle;
          a_d     = 1'b0;
        end else if (cnt_q == CTW'(1)) begin
          state_d = StPlay;
          cnt_d   = hold_len(tab_q[0]);
          a_d     = tab_q[0][CW];
        end else begin
          cnt_d = cnt_q - CTW'(1);
        end
      end
      StPlay: begin
        if (abort) begin
          state_d = StIdle;
          a_d     = 1'b0;
        end else if (cnt_q == CTW'(1)) begin
          if ({1'b0, step_q} == eff_len_q - (AW+1)'(1)) begin
            state_d = StDone;
            a_d     = 1'b0;
          end else begin
            step_d = step_q + AW'(1);
            cnt_d  = hold_len(nxt_entry);
            a_d    = nxt_entry[CW];
          end
        end else begin
          cnt_d = cnt_q - CTW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
        a_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      step_q    <= '0;
      eff_len_q <= '0;
      a_q       <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      step_q    <= step_d;
      eff_len_q <= eff_len_d;
      a_q       <= a_d;
      err_q     <= err_d;
    end
  end

  assign a       = a_q;
  assign busy    = (state_q == StInit) || (state_q == StPlay);
  assign done    = (state_q == StDone);
  assign step    = step_q;
  assign err_cnt = err_q;

endmodule
